enemy_bullet: RTL

- Fires and tracks a single downward enemy bullet for one enemy column.
- Sits directly downstream of the enemy ship block.
- Consumes the front ship's position and alive status, launches a bullet after a frame-counted delay, and moves it down each frame.
- Reports a collision with the player as a one-cycle pulse, and outputs the bullet rectangle and colour to the VGA drawing stage.

---
 rtl/enemy_bullet.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/enemy_bullet.sv
// rtl/enemy_bullet.sv - single downward enemy bullet: delayed launch, per-frame motion, player hit pulse
module enemy_bullet #(
  parameter logic [9:0]  bullet_delay_p   = 10'd5,
  parameter logic [9:0]  frames_per_sec_p = 10'd60,
  parameter logic [9:0]  step_p           = 10'd4,
  parameter logic [9:0]  bullet_w_p       = 10'd2,
  parameter logic [9:0]  bullet_h_p       = 10'd8,
  parameter logic [9:0]  screen_bot_p     = 10'd479,
  parameter logic [11:0] color_p          = {4'hF, 4'h0, 4'h0}
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       frame_i,
  input  logic       enable_i,
  input  logic       shooter_valid_i,
  input  logic [9:0] shooter_left_i,
  input  logic [9:0] shooter_right_i,
  input  logic [9:0] shooter_bot_i,
  input  logic [9:0] player_left_i,
  input  logic [9:0] player_right_i,
  input  logic [9:0] player_top_i,
  input  logic [9:0] player_bot_i,
  output logic       active_o,
  output logic [9:0] bullet_left_o,
  output logic [9:0] bullet_right_o,
  output logic [9:0] bullet_top_o,
  output logic [9:0] bullet_bot_o,
  output logic       player_hit_o,
  output logic [3:0] bullet_red_o,
  output logic [3:0] bullet_green_o,
  output logic [3:0] bullet_blue_o
);

  // Frames to wait between shots, minus one (last count value before launch)
  localparam logic [15:0] term_lp = {6'd0, bullet_delay_p} * {6'd0, frames_per_sec_p} - 16'd1;

  localparam logic [3:0] idle_s   = 4'b0001;
  localparam logic [3:0] armed_s  = 4'b0010;
  localparam logic [3:0] flying_s = 4'b0100;
  localparam logic [3:0] hit_s    = 4'b1000;

  logic [3:0]  state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [9:0]  left_q, left_d;
  logic [9:0]  top_q, top_d;

  logic [10:0] shooter_sum;
  logic [9:0]  launch_left;
  logic [9:0]  launch_top;
  logic [10:0] next_top11;
  logic [10:0] next_bot11;
  logic        off_screen;
  logic        overlap;

  assign shooter_sum = {1'b0, shooter_left_i} + {1'b0, shooter_right_i};
  assign launch_left = 10'(shooter_sum >> 1);
  assign launch_top  = shooter_bot_i + 10'd1;

  // Top is advanced in 11 bits so a step past the bottom is caught instead of wrapping
  assign next_top11 = {1'b0, top_q} + {1'b0, step_p};
  assign next_bot11 = next_top11 + {1'b0, bullet_h_p} - 11'd1;
  assign off_screen = next_top11[10] || (next_bot11 > {1'b0, screen_bot_p});

  assign bullet_left_o  = left_q;
  assign bullet_top_o   = top_q;
  assign bullet_right_o = left_q + bullet_w_p - 10'd1;
  assign bullet_bot_o   = top_q + bullet_h_p - 10'd1;

  // Inclusive rectangle intersection on the registered bullet position
  assign overlap = (left_q <= player_right_i) && (bullet_right_o >= player_left_i) &&
                   (top_q <= player_bot_i) && (bullet_bot_o >= player_top_i);

  assign active_o     = state_q[2];
  assign player_hit_o = state_q[3];

  assign bullet_red_o   = color_p[11:8];
  assign bullet_green_o = color_p[7:4];
  assign bullet_blue_o  = color_p[3:0];

  // Next-state logic: launch timing, flight stepping and hit detection
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    left_d  = left_q;
    top_d   = top_q;
    if (!enable_i) begin
      state_d = idle_s;
      count_d = 16'd0;
    end else begin
      case (state_q)
        idle_s: begin
          state_d = armed_s;
          count_d = 16'd0;
        end
        armed_s: begin
          if (frame_i) begin
            if (count_q >= term_lp) begin
              if (shooter_valid_i) begin
                state_d = flying_s;
                count_d = 16'd0;
                left_d  = launch_left;
                top_d   = launch_top;
              end
            end else begin
              count_d = count_q + 16'd1;
            end
          end
        end
        flying_s: begin
          if (overlap) begin
            state_d = hit_s;
          end else if (frame_i) begin
            if (off_screen) begin
              state_d = armed_s;
              count_d = 16'd0;
            end else begin
              top_d = 10'(next_top11);
            end
          end
        end
        hit_s: begin
          state_d = armed_s;
          count_d = 16'd0;
        end
        default: begin
          state_d = idle_s;
          count_d = 16'd0;
        end
      endcase
    end
  end

  // State and position registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= idle_s;
      count_q <= 16'd0;
      left_q  <= 10'd0;
      top_q   <= 10'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      left_q  <= left_d;
      top_q   <= top_d;
    end
  end

endmodule
